// File: rtl/ram_req_arbiter.sv
// ram_req_arbiter: shares one cpu_ram_if RAM port among NREQ requesters.
// A requester keeps ownership until the RAM reports ACCESS or the requester drops its request.
// Ports:
//   CLK, nRST                     clock and asynchronous active-low reset
//   req_ren/req_wen/req_addr/req_store  per-requester request inputs; lane i uses slice [i*W +: W]
//   req_wait                      per-requester hold signal
//   req_load                      shared read data bus
//   grant_id                      index of the current owner (debug)
//   ramREN/ramWEN/ramaddr/ramstore  RAM request outputs
//   ramload/ramstate              RAM response inputs; ramstate is 00 FREE, 01 BUSY, 10 ACCESS, 11 ERROR
// Build option: define ARB_FIXED_PRIO_EN to replace round-robin with fixed lowest-index priority.
module ram_req_arbiter #(
    parameter int NREQ = 4,
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic                   CLK,
    input  logic                   nRST,
    input  logic [NREQ-1:0]        req_ren,
    input  logic [NREQ-1:0]        req_wen,
    input  logic [NREQ*AW-1:0]     req_addr,
    input  logic [NREQ*DW-1:0]     req_store,
    output logic [NREQ-1:0]        req_wait,
    output logic [DW-1:0]          req_load,
    output logic [$clog2(NREQ)-1:0] grant_id,
    output logic                   ramREN,
    output logic                   ramWEN,
    output logic [AW-1:0]          ramaddr,
    output logic [DW-1:0]          ramstore,
    input  logic [DW-1:0]          ramload,
    input  logic [1:0]             ramstate
);
    localparam int GW = $clog2(NREQ);
    localparam logic S_IDLE = 1'b0;
    localparam logic S_OWN = 1'b1;
    logic state;
    logic [NREQ-1:0] req;
    logic [GW-1:0] pick;
    logic own, owner_req, access;
    assign req = req_ren | req_wen;
    assign own = state == S_OWN;
    assign owner_req = req[grant_id];
    assign access = ramstate == 2'b10;
`ifdef ARB_FIXED_PRIO_EN
    always_comb begin
        pick = '0;
        for (int k = NREQ - 1; k >= 0; k--)
            if (req[k]) pick = GW'(k);
    end
`else
    logic [GW-1:0] rr;
    logic found;
    int idx;
    // first requester at or after the rr pointer, wrapping modulo NREQ
    always_comb begin
        pick = '0;
        found = 1'b0;
        idx = 0;
        for (int k = 0; k < NREQ; k++) begin
            idx = (int'(rr) + k) % NREQ;
            if (!found && req[idx]) begin
                pick = GW'(idx);
                found = 1'b1;
            end
        end
    end
`endif
    // write wins when the owner asserts both enables
    assign ramWEN = own & req_wen[grant_id];
    assign ramREN = own & req_ren[grant_id] & ~req_wen[grant_id];
    assign ramaddr = own ? req_addr[grant_id*AW +: AW] : '0;
    assign ramstore = own ? req_store[grant_id*DW +: DW] : '0;
    assign req_load = ramload;
    always_comb begin
        req_wait = req;
        if (own && access) req_wait[grant_id] = 1'b0;
    end
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state <= S_IDLE;
            grant_id <= '0;
`ifndef ARB_FIXED_PRIO_EN
            rr <= '0;
`endif
        end else if (state == S_IDLE) begin
            if (|req) begin
                state <= S_OWN;
                grant_id <= pick;
            end
        end else if (!owner_req) begin
            state <= S_IDLE;
        end else if (access) begin
            state <= S_IDLE;
`ifndef ARB_FIXED_PRIO_EN
            rr <= (grant_id == GW'(NREQ - 1)) ? '0 : grant_id + 1'b1;
`endif
        end
    end
endmodule

// File: tb/tb_ram_req_arbiter.sv
// tb_ram_req_arbiter: directed self-checking bench for ram_req_arbiter.
module tb_ram_req_arbiter;
    logic CLK = 1'b0, nRST = 1'b0;
    logic [3:0] req_ren = '0, req_wen = '0, req_wait;
    logic [127:0] req_addr = '0, req_store = '0;
    logic [31:0] req_load, ramaddr, ramstore, ramload = '0;
    logic [1:0] grant_id, ramstate = 2'b00;
    logic ramREN, ramWEN;
    int checks = 0, errors = 0, cyc = 0;
    localparam logic [1:0] FREE = 2'b00, BUSY = 2'b01, ACCESS = 2'b10, ERROR = 2'b11;
    ram_req_arbiter #(.NREQ(4), .AW(32), .DW(32)) dut (
        .CLK(CLK), .nRST(nRST), .req_ren(req_ren), .req_wen(req_wen),
        .req_addr(req_addr), .req_store(req_store), .req_wait(req_wait),
        .req_load(req_load), .grant_id(grant_id), .ramREN(ramREN), .ramWEN(ramWEN),
        .ramaddr(ramaddr), .ramstore(ramstore), .ramload(ramload), .ramstate(ramstate)
    );
    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc++;
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask
    task automatic tick;
        @(posedge CLK);
        #1;
    endtask
    task automatic do_reset;
        req_ren = '0;
        req_wen = '0;
        ramstate = FREE;
        nRST = 1'b0;
        tick;
        nRST = 1'b1;
    endtask
    initial begin
        int last, exp;
        #1;
        check("rst_grant", 32'(grant_id), 0);
        check("rst_ren", 32'(ramREN), 0);
        check("rst_wen", 32'(ramWEN), 0);
        check("rst_addr", ramaddr, 0);
        do_reset;
        // single read on lane 2
        req_addr[2*32 +: 32] = 32'h40;
        req_ren[2] = 1'b1;
        #1;
        check("rd_idle_ren", 32'(ramREN), 0);
        check("rd_idle_wait", 32'(req_wait), 32'h4);
        tick;
        check("rd_grant", 32'(grant_id), 2);
        check("rd_ren", 32'(ramREN), 1);
        check("rd_addr", ramaddr, 32'h40);
        ramstate = BUSY;
        tick;
        check("rd_busy_wait", 32'(req_wait), 32'h4);
        tick;
        check("rd_busy2_addr", ramaddr, 32'h40);
        ramstate = ACCESS;
        ramload = 32'hDEADBEEF;
        #1;
        check("rd_acc_wait", 32'(req_wait), 0);
        check("rd_acc_load", req_load, 32'hDEADBEEF);
        tick;
        req_ren = '0;
        ramstate = FREE;
        #1;
        check("rd_idle_after", 32'(ramREN), 0);
        // all four lanes reading continuously
        do_reset;
        for (int i = 0; i < 4; i++) req_addr[i*32 +: 32] = 32'h1000 + 32'(i) * 32'h10;
        req_ren = 4'hF;
        last = 0;
        for (int g = 0; g < 5; g++) begin
`ifdef ARB_FIXED_PRIO_EN
            exp = 0;
`else
            exp = g % 4;
`endif
            tick;
            check("rr_grant", 32'(grant_id), 32'(exp));
            check("rr_addr", ramaddr, 32'h1000 + 32'(exp) * 32'h10);
            if (g > 0) check("rr_spacing", 32'(cyc - last), 3);
            last = cyc;
            ramstate = BUSY;
            tick;
            ramstate = ACCESS;
            #1;
            check("rr_wait", 32'(req_wait), 32'hF & ~(32'h1 << exp));
            tick;
            ramstate = FREE;
            check("rr_idle_ren", 32'(ramREN), 0);
        end
        // write wins over read on lane 1
        do_reset;
        req_addr[1*32 +: 32] = 32'h80;
        req_store[1*32 +: 32] = 32'h12345678;
        req_ren[1] = 1'b1;
        req_wen[1] = 1'b1;
        tick;
        ramstate = BUSY;
        for (int i = 0; i < 2; i++) begin
            #1;
            check("wr_wen", 32'(ramWEN), 1);
            check("wr_ren", 32'(ramREN), 0);
            check("wr_store", ramstore, 32'h12345678);
            check("wr_addr", ramaddr, 32'h80);
            tick;
        end
        ramstate = ACCESS;
        #1;
        check("wr_acc_wait", 32'(req_wait), 0);
        tick;
        req_ren = '0;
        req_wen = '0;
        ramstate = FREE;
        // ERROR retries while owned by lane 3
        do_reset;
        req_addr[3*32 +: 32] = 32'h300;
        req_ren[3] = 1'b1;
        tick;
        ramstate = ERROR;
        for (int i = 0; i < 2; i++) begin
            #1;
            check("err_grant", 32'(grant_id), 3);
            check("err_addr", ramaddr, 32'h300);
            check("err_wait", 32'(req_wait), 32'h8);
            tick;
        end
        ramstate = ACCESS;
        #1;
        check("err_acc_wait", 32'(req_wait), 0);
        tick;
        ramstate = FREE;
        req_ren = 4'b1001;
        tick;
        check("err_next_grant", 32'(grant_id), 0);
        req_ren = '0;
        tick;
        // owner lane 1 aborts mid-BUSY
        do_reset;
        req_ren[1] = 1'b1;
        tick;
        ramstate = BUSY;
        #1;
        check("ab_ren_on", 32'(ramREN), 1);
        req_ren[1] = 1'b0;
        #1;
        check("ab_ren_off", 32'(ramREN), 0);
        check("ab_wait", 32'(req_wait), 0);
        tick;
        req_ren = 4'b0110;
        tick;
        check("ab_regrant", 32'(grant_id), 1);
        req_ren = '0;
        ramstate = FREE;
        tick;
        // asynchronous reset in the middle of an owned transaction
        do_reset;
        req_ren[2] = 1'b1;
        tick;
        ramstate = ACCESS;
        tick;
        ramstate = BUSY;
        tick;
        check("rs_grant_pre", 32'(grant_id), 2);
        #2 nRST = 1'b0;
        #1;
        check("rs_ren", 32'(ramREN), 0);
        check("rs_wen", 32'(ramWEN), 0);
        check("rs_grant", 32'(grant_id), 0);
        #1 nRST = 1'b1;
        req_ren = 4'hF;
        tick;
        check("rs_restart", 32'(grant_id), 0);
        req_ren = '0;
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end
endmodule
